piso_serializer: RTL
====================

Name: piso_serializer

Overview:
Parallel-in/serial-out transmitter: the sending end of the serial bit stream consumed by the team's serial-in shift-register chains. Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per CLK cycle, with framing strobes. Sits between a word-oriented producer and a 1-bit serial link.

Parameters:
WIDTH, 4, word width in bits; legal range 2..32
MSB_FIRST, 1, 1 = bit WIDTH-1 transmitted first; 0 = bit 0 first

Ports:
CLK  input  1  clock; all state updates on rising edge
RESETN  input  1  synchronous active-low reset
I  input  WIDTH  parallel word to transmit
I_VALID  input  1  I holds a word to send
I_READY  output  1  serializer accepts a word this cycle
O  output  1  serial data bit
O_VALID  output  1  O carries a valid bit
O_LAST  output  1  O carries the final bit of the current frame

Behaviour:
- One clock; reset is synchronous and active-low: RESETN sampled low at a CLK rising edge resets all state.
- Reset state: state=IDLE, shift register=0, bit counter=0; O=0, O_VALID=0, O_LAST=0. I_READY is forced to 0 combinationally while RESETN=0.
- O, O_VALID, O_LAST are registered. I_READY is combinational from state/counter only, never from I_VALID.
- States: IDLE, SHIFT.
- IDLE: I_READY=1. I_VALID=1 at an edge -> load I into the shift register, counter=0, go to SHIFT.
- SHIFT: I_READY=1 only on the cycle O_LAST=1; otherwise 0. Each edge advances the shift register and increments the counter. O_LAST=1 when counter==WIDTH-1.
- On the last-bit cycle: I_VALID=1 -> load the new word and stay in SHIFT. This gives back-to-back frames with no bubble. I_VALID=0 -> go to IDLE, and O_VALID deasserts on the next cycle.
- Latency: word accepted at edge k. Its first bit is on O during the cycle after edge k, and it occupies O for WIDTH consecutive cycles.
- Order: MSB_FIRST=1 sends I[WIDTH-1] down to I[0]; MSB_FIRST=0 sends I[0] up to I[WIDTH-1].
- I_VALID while busy (not on the last bit): the word is not accepted. The producer must hold it; I may change without effect.
- When O_VALID=0, O is driven 0.
- Reset mid-frame: the frame is abandoned. The next cycle shows O_VALID=0 and no partial O_LAST is emitted.
- Counter width is clog2(WIDTH+1). It must never wrap past WIDTH-1 in normal operation.

Optional Feature:
PISO_PARITY_EN
- Defined: each frame is WIDTH+1 bits. After the data bits comes one even-parity bit (XOR of the loaded word). O_LAST marks the parity bit, not the final data bit. The back-to-back load happens on the parity cycle.
- Undefined: no parity bit; frame is exactly WIDTH bits, as above.

Decomposition:
- Shared package piso_pkg holds:
  - state enum (IDLE, SHIFT)
  - function for counter width (clog2)
  - localparam FRAME_LEN (WIDTH, or WIDTH+1 under PISO_PARITY_EN)
- One sub-module, piso_bit_counter, holds the frame-position counter. Inputs: clear/load, increment. Output: terminal-count flag. The FSM and shift register stay in piso_serializer.

Test Plan:
1. WIDTH=4, MSB_FIRST=1: reset, then a single I=4'b1011 with I_VALID pulse. Expect O=1,0,1,1 over the next 4 cycles with O_VALID=1, O_LAST=1 on the 4th only. Then O_VALID=0, I_READY=1.
2. Back-to-back: I_VALID held with 4'b1100 then 4'b0011. Expect O=1,1,0,0,0,0,1,1 contiguous, O_LAST on cycles 4 and 8, and I_READY high only in IDLE and on those last-bit cycles.
3. MSB_FIRST=0, I=4'b0001. Expect O=1,0,0,0.
4. Busy rejection: present 4'b1111 with I_VALID during bit 2 of frame 4'b1010, and again on the last bit. Expect 4'b1111 accepted only on the last-bit edge; O=1,0,1,0,1,1,1,1.
5. Reset mid-frame: RESETN=0 at bit 2 of 4'b1011. Expect O_VALID=0, O=0, O_LAST=0 the next cycle, and I_READY=0 while RESETN=0. After release a new word 4'b0110 transmits cleanly.
6. PISO_PARITY_EN defined, I=4'b1011. Expect O=1,0,1,1,1 (odd data weight gives parity bit 1), with O_LAST on the 5th bit.

Source files
------------

// File: rtl/piso_pkg.sv
// Shared types and sizing helpers for the PISO serializer.
// Optional macro PISO_PARITY_EN appends one even-parity bit to every frame.
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

`ifdef PISO_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

  localparam int DEFAULT_WIDTH = 4;
  localparam int FRAME_LEN     = DEFAULT_WIDTH + PARITY_BITS;

  function automatic int frame_len(input int width);
    return width + PARITY_BITS;
  endfunction

  // Position counter is sized for WIDTH+1 so the parity slot still fits.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Frame-position counter: tracks which bit of the frame is on the serial line
// and flags the final position.
module piso_bit_counter #(
  parameter int LEN = 4,
  parameter int CW  = 3
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear,
  input  logic inc,
  output logic terminal
);

  logic [CW-1:0] count;

  // Clear wins over increment so a new frame always starts from position 0.
  always_ff @(posedge clk) begin
    if (!resetn)
      count <= '0;
    else if (clear)
      count <= '0;
    else if (inc)
      count <= count + CW'(1);
  end

  assign terminal = (count == CW'(LEN - 1));

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter with valid/ready input and framed output.
// Optional macro PISO_PARITY_EN adds a trailing even-parity bit per frame.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic [WIDTH-1:0] I,
  input  logic             I_VALID,
  output logic             I_READY,
  output logic             O,
  output logic             O_VALID,
  output logic             O_LAST
);

  localparam int LEN = frame_len(WIDTH);
  localparam int CW  = cnt_width(WIDTH);

  state_t           state;
  state_t           state_next;
  logic [LEN-1:0]   sreg;
  logic [LEN-1:0]   load_word;
  logic [WIDTH-1:0] ordered;
  logic             terminal;
  logic             accept;
  logic             shifting;

  assign shifting = (state == SHIFT);
  assign accept   = I_READY && I_VALID;

  // The word is reordered at load time so the line always takes the top bit.
  always_comb begin
    ordered = '0;
    for (int k = 0; k < WIDTH; k++)
      ordered[k] = MSB_FIRST ? I[k] : I[WIDTH-1-k];
  end

`ifdef PISO_PARITY_EN
  assign load_word = {ordered, ^I};
`else
  assign load_word = ordered;
`endif

  always_ff @(posedge CLK) begin
    if (!RESETN)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (I_VALID) state_next = SHIFT;
      SHIFT:   if (terminal && !I_VALID) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    I_READY = RESETN && (!shifting || terminal);
    O_VALID = shifting;
    O_LAST  = shifting && terminal;
    O       = shifting && sreg[LEN-1];
  end

  always_ff @(posedge CLK) begin
    if (!RESETN)
      sreg <= '0;
    else if (accept)
      sreg <= load_word;
    else if (shifting)
      sreg <= sreg << 1;
  end

  piso_bit_counter #(
    .LEN(LEN),
    .CW (CW)
  ) u_bit_counter (
    .clk     (CLK),
    .resetn  (RESETN),
    .clear   (accept || (shifting && terminal)),
    .inc     (shifting),
    .terminal(terminal)
  );

endmodule
